axi_wr_ctrl: RTL and testbench

- Write-channel controller for the AXI crossbar.
- Arbitrates AW requests from M0 and M1 round-robin and decodes the target slave: S0 (IM), S1 (DM) or DS.
- Locks master/slave routing from AW grant through W last beat to B handshake, then releases.
- Drives the select lines of the W data-routing block and the B response mux, replacing AWValid-based routing with registered, transaction-scoped selects.

---
 rtl/axi_wr_pkg.sv | 18 +
 rtl/wr_addr_decode.sv | 32 +++
 rtl/axi_wr_ctrl.sv | 148 ++++++++++++++
 tb/tb_axi_wr_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the AXI write-channel controller.
//   wr_state_e : controller FSM states
//   SEL_*      : one-hot select encodings for slaves {DS,S1,S0} and masters {M1,M0}
//   *_DEFAULT  : default AWAddr[31:16] values that pick S0 and S1
package axi_wr_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wr_state_e;

  localparam logic [2:0] SEL_S0 = 3'b001;
  localparam logic [2:0] SEL_S1 = 3'b010;
  localparam logic [2:0] SEL_DS = 3'b100;
  localparam logic [1:0] SEL_M0 = 2'b01;
  localparam logic [1:0] SEL_M1 = 2'b10;

  localparam logic [15:0] S0_BASE_DEFAULT = 16'h0000;
  localparam logic [15:0] S1_BASE_DEFAULT = 16'h0001;

endpackage

// File: rtl/wr_addr_decode.sv
// Combinational AWAddr-to-slave decoder.
//   addr    : write address of the grant candidate
//   slv_sel : one-hot {DS,S1,S0}; upper 16 address bits choose S0/S1, anything else DS
module wr_addr_decode
  import axi_wr_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter logic [15:0] S0_BASE = S0_BASE_DEFAULT,
  parameter logic [15:0] S1_BASE = S1_BASE_DEFAULT
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [2:0]        slv_sel
);

  logic [15:0] addr_hi;
  logic        unused_addr_lo;

  assign addr_hi        = addr[ADDR_W-1 -: 16];
  // Only the region bits take part in routing.
  assign unused_addr_lo = ^addr[ADDR_W-17:0];

  always_comb begin
    if (addr_hi == S0_BASE) begin
      slv_sel = SEL_S0;
    end else if (addr_hi == S1_BASE) begin
      slv_sel = SEL_S1;
    end else begin
      slv_sel = SEL_DS;
    end
  end

endmodule

// File: rtl/axi_wr_ctrl.sv
// AXI write-channel controller: round-robin AW arbitration between M0 and M1,
// slave decode, and transaction-scoped routing selects held from AW grant to B handshake.
//   clk, rst                 : clock, synchronous active-high reset
//   Mx_AWValid/AWAddr/AWLen  : master write-address requests
//   Mx_AWReady               : granted master's ready, combinational from slv_awready
//   slv_awready/slv_awvalid  : AW handshake with {DS,S1,S0}
//   w_mst_sel, w_slv_sel     : W routing selects (DATA only)
//   WValid_m/WLast_m/WReady_s: muxed W handshake signals
//   b_slv_sel                : B response select (RESP only)
//   BValid_s/BReady_m        : muxed B handshake signals
//   len_err                  : one-cycle pulse, the cycle after a beat whose WLast disagrees
//                              with the remaining beat count
//   busy                     : high outside IDLE
module axi_wr_ctrl
  import axi_wr_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LEN_W   = 4,
  parameter logic [15:0] S0_BASE = S0_BASE_DEFAULT,
  parameter logic [15:0] S1_BASE = S1_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              M0_AWValid,
  input  logic [ADDR_W-1:0] M0_AWAddr,
  input  logic [LEN_W-1:0]  M0_AWLen,
  output logic              M0_AWReady,
  input  logic              M1_AWValid,
  input  logic [ADDR_W-1:0] M1_AWAddr,
  input  logic [LEN_W-1:0]  M1_AWLen,
  output logic              M1_AWReady,
  input  logic [2:0]        slv_awready,
  output logic [2:0]        slv_awvalid,
  output logic [1:0]        w_mst_sel,
  output logic [2:0]        w_slv_sel,
  input  logic              WValid_m,
  input  logic              WLast_m,
  input  logic              WReady_s,
  output logic [2:0]        b_slv_sel,
  input  logic              BValid_s,
  input  logic              BReady_m,
  output logic              len_err,
  output logic              busy
);

  wr_state_e          state;
  logic               prio;    // 0: M0 wins a tie, 1: M1 wins a tie
  logic [1:0]         grant;
  logic [2:0]         slave;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   cnt;

  logic               cand_m1;
  logic [ADDR_W-1:0]  cand_addr;
  logic [LEN_W-1:0]   cand_len;
  logic [2:0]         cand_slv;
  logic               aw_ok;
  logic               aw_hs;
  logic               w_beat;
  logic               cnt_zero;

  // M1 is the candidate when it requests alone, or on a tie when it holds priority.
  assign cand_m1   = M1_AWValid & (~M0_AWValid | prio);
  assign cand_addr = cand_m1 ? M1_AWAddr : M0_AWAddr;
  assign cand_len  = cand_m1 ? M1_AWLen : M0_AWLen;

  wr_addr_decode #(
    .ADDR_W  (ADDR_W),
    .S0_BASE (S0_BASE),
    .S1_BASE (S1_BASE)
  ) u_decode (
    .addr    (cand_addr),
    .slv_sel (cand_slv)
  );

  assign aw_ok      = |(slv_awready & slave);
  assign M0_AWReady = (state == ADDR) & grant[0] & aw_ok;
  assign M1_AWReady = (state == ADDR) & grant[1] & aw_ok;
  assign aw_hs      = (M0_AWValid & M0_AWReady) | (M1_AWValid & M1_AWReady);
  assign w_beat     = WValid_m & WReady_s;
  assign cnt_zero   = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prio        <= 1'b0;
      grant       <= '0;
      slave       <= '0;
      len         <= '0;
      cnt         <= '0;
      slv_awvalid <= '0;
      w_mst_sel   <= '0;
      w_slv_sel   <= '0;
      b_slv_sel   <= '0;
      len_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: begin
          if (M0_AWValid | M1_AWValid) begin
            grant       <= cand_m1 ? SEL_M1 : SEL_M0;
            slave       <= cand_slv;
            len         <= cand_len;
            slv_awvalid <= cand_slv;
            busy        <= 1'b1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          // A dropped AWValid simply leaves us waiting here.
          if (aw_hs) begin
            cnt         <= len;
            slv_awvalid <= '0;
            w_mst_sel   <= grant;
            w_slv_sel   <= slave;
            state       <= DATA;
          end
        end
        DATA: begin
          if (w_beat) begin
            cnt     <= cnt_zero ? cnt : cnt - LEN_W'(1);
            len_err <= WLast_m != cnt_zero;
            // WLast ends the burst even when the count disagrees.
            if (WLast_m) begin
              w_mst_sel <= '0;
              w_slv_sel <= '0;
              b_slv_sel <= slave;
              state     <= RESP;
            end
          end
        end
        RESP: begin
          if (BValid_s & BReady_m) begin
            prio      <= grant[0];
            grant     <= '0;
            slave     <= '0;
            b_slv_sel <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_ctrl.sv
// Self-checking bench for axi_wr_ctrl: a table of directed transactions, hand-written
// reset/abort sequence, then randomized transactions predicted by a transaction-level model.
module tb_axi_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        M0_AWValid, M1_AWValid;
  logic [31:0] M0_AWAddr, M1_AWAddr;
  logic [3:0]  M0_AWLen, M1_AWLen;
  logic        M0_AWReady, M1_AWReady;
  logic [2:0]  slv_awready, slv_awvalid;
  logic [1:0]  w_mst_sel;
  logic [2:0]  w_slv_sel, b_slv_sel;
  logic        WValid_m, WLast_m, WReady_s, BValid_s, BReady_m;
  logic        len_err, busy;

  int total = 0;
  int bad   = 0;
  int model_prio = 0;  // master that wins the next tie

  always #5 clk = ~clk;

  axi_wr_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .M0_AWValid  (M0_AWValid),
    .M0_AWAddr   (M0_AWAddr),
    .M0_AWLen    (M0_AWLen),
    .M0_AWReady  (M0_AWReady),
    .M1_AWValid  (M1_AWValid),
    .M1_AWAddr   (M1_AWAddr),
    .M1_AWLen    (M1_AWLen),
    .M1_AWReady  (M1_AWReady),
    .slv_awready (slv_awready),
    .slv_awvalid (slv_awvalid),
    .w_mst_sel   (w_mst_sel),
    .w_slv_sel   (w_slv_sel),
    .WValid_m    (WValid_m),
    .WLast_m     (WLast_m),
    .WReady_s    (WReady_s),
    .b_slv_sel   (b_slv_sel),
    .BValid_s    (BValid_s),
    .BReady_m    (BReady_m),
    .len_err     (len_err),
    .busy        (busy)
  );

  typedef struct {
    bit          v0;
    bit          v1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [3:0]  l0;
    logic [3:0]  l1;
    int          nb;     // beats sent; WLast on the final one
    int          stall;  // WReady-low cycles before beat 2
    int          em;     // expected granted master
    logic [2:0]  es;     // expected slave one-hot
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle view of every registered output plus AWReady and select exclusivity.
  task automatic chk_cyc(input string ph, input logic [1:0] mst, input logic [2:0] wsl,
                         input logic [2:0] bsl, input logic [2:0] aval, input logic lerr,
                         input logic bsy, input logic [1:0] awr);
    chk({ph, "_w_mst_sel"}, w_mst_sel, mst);
    chk({ph, "_w_slv_sel"}, w_slv_sel, wsl);
    chk({ph, "_b_slv_sel"}, b_slv_sel, bsl);
    chk({ph, "_slv_awvalid"}, slv_awvalid, aval);
    chk({ph, "_len_err"}, len_err, lerr);
    chk({ph, "_busy"}, busy, bsy);
    chk({ph, "_awready"}, {M1_AWReady, M0_AWReady}, awr);
    chk({ph, "_exclusive"}, 32'((w_slv_sel != 0) && (b_slv_sel != 0)), 0);
  endtask

  function automatic logic [2:0] ref_slave(input logic [31:0] a);
    int hi;
    hi = int'(a / 65536);
    if (hi == 0) return 3'b001;
    if (hi == 1) return 3'b010;
    return 3'b100;
  endfunction

  task automatic clear_inputs();
    M0_AWValid = 0; M1_AWValid = 0;
    M0_AWAddr = 0; M1_AWAddr = 0; M0_AWLen = 0; M1_AWLen = 0;
    slv_awready = 0; WValid_m = 0; WLast_m = 0; WReady_s = 0; BValid_s = 0; BReady_m = 0;
  endtask

  task automatic do_txn(input vec_t v);
    logic [1:0] ms;
    int         rem;
    logic       perr;
    int         n;
    ms = (v.em == 1) ? 2'b10 : 2'b01;
    rem = (v.em == 1) ? int'(v.l1) : int'(v.l0);
    // IDLE: present requests, no ready yet
    M0_AWValid = v.v0; M1_AWValid = v.v1;
    M0_AWAddr = v.a0; M1_AWAddr = v.a1; M0_AWLen = v.l0; M1_AWLen = v.l1;
    slv_awready = 3'b111;
    #1;
    chk_cyc("idle", 0, 0, 0, 0, 0, 0, 0);
    tick();
    // ADDR: slave not ready for a few cycles
    n = $urandom_range(0, 2);
    for (int j = 0; j < n; j++) begin
      slv_awready = ~v.es;
      #1;
      chk_cyc("addr_wait", 0, 0, 0, v.es, 0, 1, 0);
      tick();
    end
    slv_awready = v.es | 3'($urandom);
    #1;
    chk_cyc("addr_hs", 0, 0, 0, v.es, 0, 1, ms);
    tick();
    // DATA: the losing master, if any, keeps requesting
    if (v.em == 1) M1_AWValid = 0; else M0_AWValid = 0;
    slv_awready = 3'b111;
    perr = 0;
    for (int i = 0; i < v.nb; i++) begin
      n = (i == 2 && v.stall > 0) ? v.stall : $urandom_range(0, 1);
      for (int j = 0; j < n; j++) begin
        if (i == 2 && v.stall > 0) begin
          WValid_m = 1; WReady_s = 0;
        end else if ($urandom_range(0, 1) == 1) begin
          WValid_m = 0; WReady_s = 1;
        end else begin
          WValid_m = 1; WReady_s = 0;
        end
        WLast_m = (i == v.nb - 1);
        #1;
        chk_cyc("data_stall", ms, v.es, 0, 0, perr, 1, 0);
        perr = 0;
        tick();
      end
      WValid_m = 1; WReady_s = 1; WLast_m = (i == v.nb - 1);
      #1;
      chk_cyc("data_beat", ms, v.es, 0, 0, perr, 1, 0);
      perr = ((i == v.nb - 1) != (rem == 0));
      rem = (rem > 0) ? rem - 1 : 0;
      tick();
    end
    WValid_m = 0; WReady_s = 0; WLast_m = 0;
    // RESP
    n = $urandom_range(0, 2);
    for (int j = 0; j < n; j++) begin
      if ($urandom_range(0, 1) == 1) begin
        BValid_s = 1; BReady_m = 0;
      end else begin
        BValid_s = 0; BReady_m = 1;
      end
      #1;
      chk_cyc("resp_wait", 0, 0, v.es, 0, perr, 1, 0);
      perr = 0;
      tick();
    end
    BValid_s = 1; BReady_m = 1;
    #1;
    chk_cyc("resp_hs", 0, 0, v.es, 0, perr, 1, 0);
    tick();
    BValid_s = 0; BReady_m = 0;
    model_prio = (v.em == 1) ? 0 : 1;
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    tbl[0] = '{1, 1, 32'h0000_0100, 32'h0001_0000, 4'd2, 4'd1, 3,  0, 0, 3'b001};
    tbl[1] = '{1, 1, 32'h0000_0200, 32'h0003_0000, 4'd1, 4'd2, 3,  0, 1, 3'b100};
    tbl[2] = '{1, 1, 32'h0001_0010, 32'h0000_0000, 4'd0, 4'd0, 1,  0, 0, 3'b010};
    tbl[3] = '{0, 1, 32'h0000_0000, 32'h0001_0040, 4'd0, 4'd3, 4,  0, 1, 3'b010};
    tbl[4] = '{1, 0, 32'h0005_0000, 32'h0000_0000, 4'd1, 4'd0, 2,  0, 0, 3'b100};
    tbl[5] = '{0, 1, 32'h0000_0000, 32'h0000_0080, 4'd0, 4'd1, 1,  0, 1, 3'b001};
    tbl[6] = '{1, 0, 32'h0001_0000, 32'h0000_0000, 4'd0, 4'd0, 2,  0, 0, 3'b010};
    tbl[7] = '{0, 1, 32'h0000_0000, 32'h0000_0000, 4'd0, 4'd7, 8,  5, 1, 3'b001};
    tbl[8] = '{1, 1, 32'hFFFF_0000, 32'h0001_0000, 4'd15, 4'd3, 16, 0, 0, 3'b100};

    clear_inputs();
    rst = 1;
    tick();
    tick();
    chk_cyc("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 0;

    foreach (tbl[k]) do_txn(tbl[k]);

    // Reset mid-burst after an M0 grant has handed priority to M1.
    do_txn('{1, 0, 32'h0000_0000, 32'h0, 4'd0, 4'd0, 1, 0, 0, 3'b001});
    M0_AWValid = 1; M0_AWAddr = 32'h0001_0000; M0_AWLen = 4'd3; slv_awready = 3'b111;
    tick();
    tick();
    M0_AWValid = 0; WValid_m = 1; WReady_s = 1;
    #1;
    chk_cyc("abort_data", 2'b01, 3'b010, 0, 0, 0, 1, 0);
    rst = 1;
    tick();
    clear_inputs();
    #1;
    chk_cyc("abort_reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    model_prio = 0;
    tick();
    chk_cyc("abort_idle", 0, 0, 0, 0, 0, 0, 0);
    do_txn('{1, 1, 32'h0000_0004, 32'h0000_0008, 4'd1, 4'd1, 2, 0, 0, 3'b001});

    // Randomized transactions predicted from the arbitration and decode rules.
    for (int k = 0; k < 40; k++) begin
      int r;
      rv.v0 = 1'($urandom_range(0, 1));
      rv.v1 = rv.v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int m = 0; m < 2; m++) begin
        logic [31:0] a;
        r = $urandom_range(0, 2);
        a = $urandom;
        if (r == 0) a[31:16] = 16'h0000;
        else if (r == 1) a[31:16] = 16'h0001;
        else a[31:16] = 16'($urandom_range(2, 65535));
        if (m == 0) rv.a0 = a; else rv.a1 = a;
      end
      rv.l0 = 4'($urandom_range(0, 15));
      rv.l1 = 4'($urandom_range(0, 15));
      rv.em = (rv.v0 && rv.v1) ? model_prio : (rv.v1 ? 1 : 0);
      rv.es = ref_slave((rv.em == 1) ? rv.a1 : rv.a0);
      r = (rv.em == 1) ? int'(rv.l1) : int'(rv.l0);
      rv.nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, r + 2) : r + 1;
      rv.stall = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 0;
      do_txn(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
